// File: rtl/line_window_gen_if.sv
// rtl/line_window_gen_if.sv - line-buffer RAM port bundle for line_window_gen
//   lb0_*      : buffer 0 (row y-1) port-A write, port-B read data
//   lb1_*      : buffer 1 (row y-2) port-A write, port-B read data
//   lb_addr_b  : shared port-B read address
//   master     : generator side (drives writes and read address)
//   slave      : RAM side (returns read data)
interface line_window_gen_if #(
    parameter int ADDR_W = 11
);
    logic              lb0_we;
    logic [ADDR_W-1:0] lb0_addr_a;
    logic [7:0]        lb0_din;
    logic [7:0]        lb0_dout;
    logic              lb1_we;
    logic [ADDR_W-1:0] lb1_addr_a;
    logic [7:0]        lb1_din;
    logic [7:0]        lb1_dout;
    logic [ADDR_W-1:0] lb_addr_b;

    modport master (
        output lb0_we, lb0_addr_a, lb0_din,
        input  lb0_dout,
        output lb1_we, lb1_addr_a, lb1_din,
        input  lb1_dout,
        output lb_addr_b
    );

    modport slave (
        input  lb0_we, lb0_addr_a, lb0_din,
        output lb0_dout,
        input  lb1_we, lb1_addr_a, lb1_din,
        output lb1_dout,
        input  lb_addr_b
    );
endinterface

// File: rtl/line_window_gen.sv
// rtl/line_window_gen.sv - raster stream to 3-row vertical column generator
//   clk, rst_n        : clock, asynchronous active-low reset
//   pix_in/pix_valid  : input pixel stream, no backpressure
//   sof               : start of frame, qualified by pix_valid
//   lb                : two external line-buffer RAMs (master side)
//   col_top/mid/bot   : rows y-2, y-1, y at column col_x (zero above image top)
//   col_valid         : one-cycle pulse per input pixel, 2 cycles after it
//   col_x/col_y       : coordinates of the current column
//   frame_done        : pulses with the column of the last pixel of a frame
module line_window_gen #(
    parameter int IMG_WIDTH  = 2000,
    parameter int IMG_HEIGHT = 2000,
    parameter int ADDR_W     = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        pix_in,
    input  logic              pix_valid,
    input  logic              sof,
    line_window_gen_if.master lb,
    output logic [7:0]        col_top,
    output logic [7:0]        col_mid,
    output logic [7:0]        col_bot,
    output logic              col_valid,
    output logic [ADDR_W-1:0] col_x,
    output logic [10:0]       col_y,
    output logic              frame_done
);
    localparam logic [ADDR_W-1:0] X_LAST = ADDR_W'(IMG_WIDTH - 1);
    localparam logic [10:0]       Y_LAST = 11'(IMG_HEIGHT - 1);

    logic [ADDR_W-1:0] x_cnt;
    logic [10:0]       y_cnt;
    logic              start;
    logic [ADDR_W-1:0] x_cur;
    logic [10:0]       y_cur;

    logic              s1_valid;
    logic [7:0]        s1_pix;
    logic [ADDR_W-1:0] s1_x;
    logic [10:0]       s1_y;

    // sof overrides the running counters for the pixel that carries it
    assign start = pix_valid & sof;
    assign x_cur = start ? '0 : x_cnt;
    assign y_cur = start ? '0 : y_cnt;

    // Read address is issued in the same cycle as the pixel so the registered
    // RAM output lines up with the pixel once it reaches stage 1.
    assign lb.lb_addr_b = x_cur;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (pix_valid) begin
            if (x_cur == X_LAST) begin
                x_cnt <= '0;
                y_cnt <= (y_cur == Y_LAST) ? 11'd0 : 11'(y_cur + 11'd1);
            end else begin
                x_cnt <= ADDR_W'(x_cur + 1'b1);
                y_cnt <= y_cur;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_pix   <= '0;
            s1_x     <= '0;
            s1_y     <= '0;
        end else begin
            s1_valid <= pix_valid;
            if (pix_valid) begin
                s1_pix <= pix_in;
                s1_x   <= x_cur;
                s1_y   <= y_cur;
            end
        end
    end

    // Stage 1: both buffers are rewritten at column x after being read, so
    // buffer 0 receives the current row and buffer 1 receives what buffer 0
    // held (the row above). The write address trails the read address by one
    // pixel, so they never collide while IMG_WIDTH >= 2.
    assign lb.lb0_we     = s1_valid;
    assign lb.lb0_addr_a = s1_x;
    assign lb.lb0_din    = s1_pix;
    assign lb.lb1_we     = s1_valid;
    assign lb.lb1_addr_a = s1_x;
    assign lb.lb1_din    = s1_valid ? lb.lb0_dout : 8'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_top    <= '0;
            col_mid    <= '0;
            col_bot    <= '0;
            col_x      <= '0;
            col_y      <= '0;
            col_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            col_valid  <= s1_valid;
            frame_done <= s1_valid && (s1_x == X_LAST) && (s1_y == Y_LAST);
            if (s1_valid) begin
                // Rows above the image top read stale buffer data; mask to 0.
                col_bot <= s1_pix;
                col_mid <= (s1_y >= 11'd1) ? lb.lb0_dout : 8'd0;
                col_top <= (s1_y >= 11'd2) ? lb.lb1_dout : 8'd0;
                col_x   <= s1_x;
                col_y   <= s1_y;
            end
        end
    end
endmodule

// File: doc/line_window_gen.md
Name: line_window_gen

Overview:
- Front end of the 2D FIR datapath: turns a raster pixel stream into 3-row vertical columns (rows y-2, y-1, y) for the downstream 3x3 window/MAC stage.
- Owns two external 8-bit simple dual-port line-buffer RAMs (port A write, port B registered read, 1-cycle read latency, DEPTH >= IMG_WIDTH) and drives all of their address, data and write-enable ports.
- Applies zero padding above the image top.

Parameters:
IMG_WIDTH, 2000, pixels per line; legal range 2..2000
IMG_HEIGHT, 2000, lines per frame; legal range 1..2047
ADDR_W, 11, line-buffer address width; must satisfy 2**ADDR_W >= IMG_WIDTH

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
pix_in  in  8  input pixel
pix_valid  in  1  pix_in valid this cycle; there is no backpressure
sof  in  1  start of frame; qualified by pix_valid; marks pixel (0,0)
lb0_we  out  1  line buffer 0 port-A write enable (holds row y-1)
lb0_addr_a  out  ADDR_W  line buffer 0 write address
lb0_din  out  8  line buffer 0 write data
lb0_dout  in  8  line buffer 0 port-B read data
lb1_we  out  1  line buffer 1 port-A write enable (holds row y-2)
lb1_addr_a  out  ADDR_W  line buffer 1 write address
lb1_din  out  8  line buffer 1 write data
lb1_dout  in  8  line buffer 1 port-B read data
lb_addr_b  out  ADDR_W  shared read address for both buffers
col_top  out  8  pixel (x, y-2), or 0 when y<2
col_mid  out  8  pixel (x, y-1), or 0 when y<1
col_bot  out  8  pixel (x, y)
col_valid  out  1  column outputs valid, 1-cycle pulse per input pixel
col_x  out  ADDR_W  column index of the current output
col_y  out  11  row index of the current output
frame_done  out  1  pulses with col_valid for pixel (IMG_WIDTH-1, IMG_HEIGHT-1)

Behaviour:
- Reset (asynchronous, rst_n=0): x/y counters=0; all pipeline valids=0; lb0_we=lb1_we=0; all address and data outputs=0; col_*=0; col_valid=0; frame_done=0.
- Stage 0, cycle t, pix_valid=1:
  - Capture pix_in, x, y into the stage-1 register.
  - Drive lb_addr_b=x combinationally from the counter, or from sof-forced 0.
  - Advance counters: x increments; at x=IMG_WIDTH-1, x wraps to 0 and y increments; at (IMG_WIDTH-1, IMG_HEIGHT-1), both wrap to 0.
- Stage 1, cycle t+1: lbN_dout holds stored pixel x.
  - Write lb0_addr_a=x with lb0_din=stage-1 pixel.
  - Write lb1_addr_a=x with lb1_din=lb0_dout (row shift).
  - Both we asserted for exactly one cycle per pixel.
  - Register outputs: col_bot=pixel; col_mid=(y>=1)?lb0_dout:0; col_top=(y>=2)?lb1_dout:0.
- Stage 2, cycle t+2: col_valid=1 together with col_x/col_y/frame_done.
- Latency pix_valid -> col_valid is exactly 2 cycles; full throughput of 1 pixel/cycle; gaps in pix_valid are allowed.
- Write and read never hit the same address in one cycle, because IMG_WIDTH >= 2.
- sof with pix_valid:
  - Forces x=0, y=0 for that pixel regardless of counter state.
  - A mid-line/mid-frame sof abandons the partial frame.
  - Pixels already in stages 1-2 complete normally with their own x/y tags.
- sof without pix_valid is ignored.
- The first frame after reset needs no sof; counters start at (0,0).
- Stale line-buffer contents are never visible: the y<2 masking zero-fills them.
- rst_n asserted mid-line: everything clears immediately; in-flight writes are dropped; the next pixel is (0,0).
- col_valid=0 cycles: col_top/mid/bot/x/y hold their last values; frame_done=0.

Test Plan:
- Reset, then IMG_WIDTH=4, IMG_HEIGHT=3; stream pixel value 16*y+x continuously -> col_valid first high 2 cycles after the first pix_valid.
  - Row 0 columns: (0,0,x).
  - Row 1, x=2: top=0, mid=2, bot=18.
  - Row 2, x=3: top=3, mid=19, bot=35.
  - frame_done high only with (3,2).
- Same frame with pix_valid toggled 1,0,0,1,... -> identical column values and order; lbN_we pulse exactly once per pixel; no col_valid on idle cycles.
- Two back-to-back frames, no sof on the second -> second frame row 0 has top=mid=0 despite buffers holding frame-1 data; frame_done pulses twice.
- sof asserted at pixel (2,1) of a frame -> that pixel emitted as col_x=0, col_y=0 with top=mid=0; the preceding in-flight column (1,1) is still emitted correctly.
- rst_n pulsed low for 1 cycle mid-row -> col_valid=0 and all outputs 0 immediately (asynchronous); the next pixel is tagged (0,0).
- IMG_WIDTH=2000 default, 3 full lines of random data -> lb_addr_b/lb*_addr_a span 0..1999 and wrap; row-2 columns equal a reference model for all 2000 x.
